// File: rtl/pattern_det_pkg.sv
// pattern_det_pkg: shared state type and default sizing for the pattern detector.
package pattern_det_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   localparam int DEFAULT_PAT_W = 4;
   localparam int DEFAULT_CNT_W = 8;
   localparam logic [DEFAULT_PAT_W-1:0] DEFAULT_PAT = 4'b1001;

endpackage

// File: rtl/pattern_shift_matcher.sv
// pattern_shift_matcher: serial window with fill tracking and a compare of the window after the next shift.
module pattern_shift_matcher #(
   parameter int PAT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             shift_en,
   input  logic             din,
   input  logic [PAT_W-1:0] pattern,
   output logic             full,
   output logic             hit
);

   localparam int FW = $clog2(PAT_W + 1);

   logic [PAT_W-1:0] win_q, win_d, win_nxt;
   logic [FW-1:0]    fill_q, fill_d;

   // full means the bit being shifted now completes (or extends) a whole window
   always_comb begin
      win_nxt = {win_q[PAT_W-2:0], din};
      full    = fill_q >= FW'(PAT_W - 1);
      hit     = win_nxt == pattern;
      win_d   = clear ? '0 : shift_en ? win_nxt : win_q;
      fill_d  = clear ? '0 : (shift_en && fill_q != FW'(PAT_W)) ? fill_q + 1'b1 : fill_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_q  <= '0;
         fill_q <= '0;
      end else begin
         win_q  <= win_d;
         fill_q <= fill_d;
      end
   end

endmodule

// File: rtl/pattern_det_ctrl.sv
// pattern_det_ctrl: configurable serial pattern detector sequencing a shift matcher through fill, run and done.
module pattern_det_ctrl
   import pattern_det_pkg::*;
#(
   parameter int               PAT_W   = DEFAULT_PAT_W,
   parameter int               CNT_W   = DEFAULT_CNT_W,
   parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(DEFAULT_PAT)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic [CNT_W-1:0] cfg_target,
   input  logic             start,
   input  logic             stop,
   input  logic             din,
   input  logic             din_valid,
   output logic             match,
   output logic [CNT_W-1:0] match_count,
   output logic             busy,
   output logic             done
);

   state_e           state_q, state_d;
   logic [PAT_W-1:0] pat_q, pat_d;
   logic [CNT_W-1:0] tgt_q, tgt_d, cnt_q, cnt_d, cnt_inc;
   logic             match_q, match_d;
   logic             clear, shift_en, full, hit;

   pattern_shift_matcher #(.PAT_W(PAT_W)) u_matcher (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (clear),
      .shift_en (shift_en),
      .din      (din),
      .pattern  (pat_q),
      .full     (full),
      .hit      (hit)
   );

   always_comb begin
      state_d  = state_q;
      pat_d    = pat_q;
      tgt_d    = tgt_q;
      cnt_d    = cnt_q;
      match_d  = 1'b0;
      clear    = 1'b0;
      shift_en = 1'b0;
      cnt_inc  = cnt_q + 1'b1;
      if (cfg_valid && cfg_ready) begin
         pat_d = cfg_pattern;
         tgt_d = cfg_target;
      end
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (stop) begin
               state_d = ST_IDLE;
            end else if (start) begin
               state_d = ST_FILL;
               clear   = 1'b1;
               cnt_d   = '0;
            end
         end
         ST_FILL, ST_RUN: begin
            shift_en = din_valid;
            if (din_valid && full && state_q == ST_FILL) state_d = ST_RUN;
            // a stop on the same edge still lets this bit's match be counted
            if (din_valid && full && hit) begin
               match_d = 1'b1;
               cnt_d   = &cnt_q ? cnt_q : cnt_inc;
               if (tgt_q != '0 && cnt_inc == tgt_q) state_d = ST_DONE;
            end
            if (stop) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pat_q   <= DEF_PAT;
         tgt_q   <= '0;
         cnt_q   <= '0;
         match_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         tgt_q   <= tgt_d;
         cnt_q   <= cnt_d;
         match_q <= match_d;
      end
   end

   assign cfg_ready   = state_q == ST_IDLE || state_q == ST_DONE;
   assign busy        = state_q == ST_FILL || state_q == ST_RUN;
   assign done        = state_q == ST_DONE;
   assign match       = match_q;
   assign match_count = cnt_q;

endmodule

// File: tb/tb_pattern_det_ctrl.sv
// tb_pattern_det_ctrl: directed and random checks of two detector instances (8-bit and 2-bit counters)
// against a bit-history reference model.
module tb_pattern_det_ctrl;

   logic       clk = 1'b0, rst_n = 1'b0;
   logic       cfg_valid = 1'b0, start = 1'b0, stop = 1'b0, din = 1'b0, din_valid = 1'b0;
   logic [3:0] cfg_pattern = '0;
   logic [7:0] cfg_target = '0;
   logic       m0, b0, d0, r0, m1, b1, d1, r1;
   logic [7:0] mc0;
   logic [1:0] mc1;

   always #5 clk = ~clk;

   pattern_det_ctrl dut0 (
      .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(r0),
      .cfg_pattern(cfg_pattern), .cfg_target(cfg_target), .start(start), .stop(stop),
      .din(din), .din_valid(din_valid), .match(m0), .match_count(mc0), .busy(b0), .done(d0)
   );

   pattern_det_ctrl #(.CNT_W(2)) dut1 (
      .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(r1),
      .cfg_pattern(cfg_pattern), .cfg_target(cfg_target[1:0]), .start(start), .stop(stop),
      .din(din), .din_valid(din_valid), .match(m1), .match_count(mc1), .busy(b1), .done(d1)
   );

   int errors = 0, checks = 0, pulses0 = 0, pulses1 = 0;
   int m_busy[2], m_done[2], m_match[2], m_cnt[2], m_tgt[2], m_pat[2], m_hist[2], m_n[2];
   int cmax[2] = '{255, 3};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 2; i++) begin
         m_busy[i] = 0; m_done[i] = 0; m_match[i] = 0; m_cnt[i] = 0;
         m_tgt[i] = 0; m_pat[i] = 9; m_hist[i] = 0; m_n[i] = 0;
      end
   endfunction

   // history of valid bits since start; a match is the last four bits equal to the pattern
   function automatic void model_step(input int i);
      m_match[i] = 0;
      if (cfg_valid && m_busy[i] == 0) begin
         m_pat[i] = int'(cfg_pattern);
         m_tgt[i] = int'(cfg_target) % (cmax[i] + 1);
      end
      if (m_busy[i] != 0) begin
         if (din_valid) begin
            m_hist[i] = ((m_hist[i] << 1) | int'(din)) & 15;
            m_n[i]++;
            if (m_n[i] >= 4 && m_hist[i] == m_pat[i]) begin
               m_match[i] = 1;
               if (m_cnt[i] < cmax[i]) m_cnt[i]++;
               if (m_tgt[i] != 0 && m_cnt[i] == m_tgt[i]) begin
                  m_busy[i] = 0;
                  m_done[i] = 1;
               end
            end
         end
         if (stop) begin
            m_busy[i] = 0;
            m_done[i] = 0;
         end
      end else if (stop) begin
         m_done[i] = 0;
      end else if (start) begin
         m_busy[i] = 1; m_done[i] = 0; m_hist[i] = 0; m_n[i] = 0; m_cnt[i] = 0;
      end
   endfunction

   task automatic compare_all();
      chk("match0", 32'(m0), m_match[0]);
      chk("count0", 32'(mc0), m_cnt[0]);
      chk("busy0", 32'(b0), m_busy[0]);
      chk("done0", 32'(d0), m_done[0]);
      chk("ready0", 32'(r0), 32'(m_busy[0] == 0));
      chk("match1", 32'(m1), m_match[1]);
      chk("count1", 32'(mc1), m_cnt[1]);
      chk("busy1", 32'(b1), m_busy[1]);
      chk("done1", 32'(d1), m_done[1]);
      chk("ready1", 32'(r1), 32'(m_busy[1] == 0));
   endtask

   task automatic step(input logic cv, input logic [3:0] cp, input logic [7:0] ct,
                       input logic s, input logic sp, input logic d, input logic dv);
      cfg_valid = cv; cfg_pattern = cp; cfg_target = ct;
      start = s; stop = sp; din = d; din_valid = dv;
      model_step(0);
      model_step(1);
      @(posedge clk);
      #1;
      if (m0) pulses0++;
      if (m1) pulses1++;
      compare_all();
   endtask

   task automatic bits(input logic [15:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) step(1'b0, 4'h0, 8'h0, 1'b0, 1'b0, v[i], 1'b1);
   endtask

   task automatic nop();
      step(1'b0, 4'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all();
      chk("rst_ready", 32'(r0), 1);
      rst_n = 1'b1;

      // default pattern 1001, free-running, overlapping matches
      step(1'b0, 4'h0, 8'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("busy_at_start", 32'(b0), 1);
      pulses0 = 0;
      bits(16'b1001001, 7);
      chk("cnt_default", 32'(mc0), 2);
      chk("pulses_default", 32'(pulses0), 2);
      step(1'b0, 4'h0, 8'h0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("stop_idle", 32'(b0), 0);
      chk("stop_keeps_cnt", 32'(mc0), 2);

      // config and start together, target 3
      step(1'b1, 4'b0110, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      bits(16'b0110110110, 10);
      chk("done_t3", 32'(d0), 1);
      chk("cnt_t3", 32'(mc0), 3);
      chk("busy_t3", 32'(b0), 0);
      bits(16'b01100110, 8);
      chk("done_holds_cnt", 32'(mc0), 3);

      // stop from DONE, then a gapped stream
      step(1'b0, 4'h0, 8'h0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("done_cleared", 32'(d0), 0);
      step(1'b1, 4'b1001, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      pulses0 = 0;
      bits(16'b1, 1); nop(); bits(16'b0, 1); nop(); nop(); bits(16'b0, 1); nop(); bits(16'b1, 1);
      chk("gap_pulses", 32'(pulses0), 1);
      step(1'b0, 4'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 4'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 4'h0, 8'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 4'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("invalid_ignored", 32'(mc0), 1);

      // config rejected while busy; stop coincident with a match
      step(1'b1, 4'b0110, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("ready_busy", 32'(r0), 0);
      bits(16'b001, 3);
      chk("old_pattern", 32'(mc0), 2);
      bits(16'b00, 2);
      step(1'b0, 4'h0, 8'h0, 1'b0, 1'b1, 1'b1, 1'b1);
      chk("stop_match_pulse", 32'(m0), 1);
      chk("stop_match_cnt", 32'(mc0), 3);
      chk("stop_match_idle", 32'(b0), 0);

      // saturation on the 2-bit counter
      step(1'b1, 4'b1111, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      pulses1 = 0;
      bits(16'hFF, 8);
      chk("sat_cnt1", 32'(mc1), 3);
      chk("sat_cnt0", 32'(mc0), 5);
      chk("sat_pulses1", 32'(pulses1), 5);

      // start and stop together while idle
      step(1'b0, 4'h0, 8'h0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 4'h0, 8'h0, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("stop_wins", 32'(b0), 0);

      // asynchronous reset mid-run restores the default pattern
      step(1'b1, 4'b0110, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      bits(16'b011011, 6);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      compare_all();
      chk("async_busy", 32'(b0), 0);
      chk("async_cnt", 32'(mc0), 0);
      @(negedge clk) rst_n = 1'b1;
      step(1'b0, 4'h0, 8'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      bits(16'b1001, 4);
      chk("def_pat_restored", 32'(mc0), 1);

      // random traffic
      for (int n = 0; n < 500; n++) begin
         step(1'($urandom_range(0, 7) == 0),
              ($urandom_range(0, 1) != 0) ? 4'b1001 : 4'($urandom),
              8'($urandom_range(0, 4)),
              1'($urandom_range(0, 9) == 0),
              1'($urandom_range(0, 24) == 0),
              1'($urandom),
              1'($urandom_range(0, 3) != 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
